// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
// Shared types and constants for the bit serializer.
//   - state_e    : 2-bit FSM state encoding (PAR exists only in parity builds)
//   - DATA_W_DEF : default word width
//   - GAP_DEF    : default number of idle cycles after each frame
//   - PARITY_EN  : 1 when BIT_SERIALIZER_PARITY_EN is defined
//   - even_parity: XOR reduction of a zero-extended word
// Build option: define BIT_SERIALIZER_PARITY_EN to append an even-parity bit.
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int GAP_DEF    = 0;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2,
    PAR   = 2'd3
  } state_e;
`else
  localparam bit PARITY_EN = 1'b0;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_e;
`endif

  // Even parity of a word; callers zero-extend narrower words to 32 bits.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Parallel-in handshake plus serial-out bundle of the bit serializer.
//   s_valid   : parallel word offered            (master -> slave)
//   s_data    : parallel word, DATA_W bits        (master -> slave)
//   s_ready   : serializer accepts word this cycle(slave -> master)
//   ser_out   : serial bit                        (slave -> master)
//   ser_valid : ser_out carries a frame bit       (slave -> master)
//   word_done : pulse on the final frame bit      (slave -> master)
//   busy      : serializer is not idle            (slave -> master)
// Build option: none (see BIT_SERIALIZER_PARITY_EN in the package).
// -----------------------------------------------------------------------------
interface bit_serializer_if #(
  parameter int DATA_W = bit_serializer_pkg::DATA_W_DEF
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              ser_out;
  logic              ser_valid;
  logic              word_done;
  logic              busy;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  ser_out,
    input  ser_valid,
    input  word_done,
    input  busy
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output ser_out,
    output ser_valid,
    output word_done,
    output busy
  );

endinterface

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Accepts a parallel word on a valid/ready handshake and shifts it out one bit
// per clock, optionally followed by an even-parity bit and GAP idle cycles.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bit_serializer_if.slave (s_valid, s_data in; s_ready, ser_out,
//         ser_valid, word_done, busy out -- all outputs registered)
// Parameters: DATA_W (2..32), MSB_FIRST (1 = MSB first), GAP (0..15).
// Build option: BIT_SERIALIZER_PARITY_EN adds the PAR state / parity bit.
// -----------------------------------------------------------------------------
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = GAP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  bit_serializer_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
  localparam logic [3:0]       GAP_LEN  = 4'(GAP);
  localparam bit               HAS_GAP  = (GAP > 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;   // bits driven so far in this frame
  logic [3:0]        gap_cnt_q, gap_cnt_d;   // gap cycles elapsed, 1-based
  logic [DATA_W-1:0] sreg_q, sreg_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic ser_out_q, ser_out_d;
  logic ser_valid_q, ser_valid_d;
  logic word_done_q, word_done_d;
  logic busy_q, busy_d;
  logic s_ready_q, s_ready_d;

  logic accept;

  // s_ready is registered, so a word can only be taken in a cycle the
  // block advertised as the last of a frame (or idle).
  assign accept = bus.s_valid & s_ready_q;

  assign bus.s_ready   = s_ready_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.busy      = busy_q;

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 4'd0;
      sreg_q      <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sreg_q      <= sreg_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
      s_ready_q   <= s_ready_d;
    end
  end

  // Next-state and datapath logic; an accept overrides every other transition.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sreg_d    = sreg_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d     = par_q;
`endif
    if (accept) begin
      state_d   = SHIFT;
      sreg_d    = bus.s_data;
      bit_cnt_d = CNT_W'(1);
      gap_cnt_d = 4'd0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d     = even_parity(32'(bus.s_data));
`endif
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          gap_cnt_d = 4'd0;
        end
        SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            state_d   = PAR;
            gap_cnt_d = 4'd0;
`else
            state_d   = HAS_GAP ? GAPW : IDLE;
            gap_cnt_d = HAS_GAP ? 4'd1 : 4'd0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            // Move the next bit into the position ser_out is taken from.
            sreg_d    = (MSB_FIRST != 0) ? {sreg_q[DATA_W-2:0], 1'b0}
                                         : {1'b0, sreg_q[DATA_W-1:1]};
          end
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        PAR: begin
          bit_cnt_d = '0;
          state_d   = HAS_GAP ? GAPW : IDLE;
          gap_cnt_d = HAS_GAP ? 4'd1 : 4'd0;
        end
`endif
        GAPW: begin
          if (gap_cnt_q == GAP_LEN) begin
            state_d   = IDLE;
            gap_cnt_d = 4'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          gap_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the cycle in which that state is active.
  always_comb begin
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
    busy_d      = 1'b0;
    s_ready_d   = 1'b0;
    case (state_d)
      IDLE: begin
        s_ready_d = 1'b1;
      end
      SHIFT: begin
        ser_valid_d = 1'b1;
        busy_d      = 1'b1;
        ser_out_d   = (MSB_FIRST != 0) ? sreg_d[DATA_W-1] : sreg_d[0];
        // The last data bit ends the frame only when no parity bit follows.
        word_done_d = (bit_cnt_d == LAST_BIT) && !PARITY_EN;
        s_ready_d   = (bit_cnt_d == LAST_BIT) && !PARITY_EN && !HAS_GAP;
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PAR: begin
        ser_valid_d = 1'b1;
        busy_d      = 1'b1;
        ser_out_d   = par_d;
        word_done_d = 1'b1;
        s_ready_d   = !HAS_GAP;
      end
`endif
      GAPW: begin
        busy_d    = 1'b1;
        s_ready_d = (gap_cnt_d == GAP_LEN);
      end
      default: begin
        s_ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 8: word width in bits, legal range 2..32.
REQ-003 Parameter MSB_FIRST, default 1: 1 sends bit DATA_W-1 first, 0 sends bit 0 first.
REQ-004 Parameter GAP, default 0: idle cycles inserted after each frame, legal range 0..15.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port s_valid  input  1  parallel word offered.
REQ-008 Port s_ready  output  1  block accepts word this cycle.
REQ-009 Port s_data  input  DATA_W  parallel word.
REQ-010 Port ser_out  output  1  serial bit; feeds the downstream sequence-detector FSM input.
REQ-011 Port ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-012 Port word_done  output  1  one-cycle pulse on the final frame bit.
REQ-013 Port busy  output  1  state is not IDLE.

Function
REQ-014 A word SHALL be accepted only on a cycle where s_valid and s_ready are both 1, and s_data SHALL be captured into the shift register on that cycle.
REQ-015 The FSM SHALL have states IDLE, SHIFT, PAR and GAPW (PAR only when REQ-029 applies).
REQ-016 Transitions:
- IDLE->SHIFT on accept.
- SHIFT->SHIFT until DATA_W bits have been sent.
- After the last bit: ->PAR if parity is enabled; else ->GAPW if GAP>0; else ->SHIFT on accept, or ->IDLE with no accept.
- PAR exits the same way as the last SHIFT cycle.
- GAPW lasts GAP cycles, then ->SHIFT on accept or ->IDLE.
REQ-017 All outputs SHALL be registered, and the first bit of an accepted word SHALL appear on ser_out one cycle after the accept cycle.
REQ-018 ser_valid SHALL be 1 exactly during SHIFT and PAR cycles, and ser_out SHALL be 0 whenever ser_valid is 0.
REQ-019 s_ready SHALL be 1 in IDLE and in the final cycle of a frame including gap (last data bit, PAR, or last GAPW cycle); it SHALL be 0 otherwise, giving gapless back-to-back words when GAP=0.
REQ-020 word_done SHALL pulse high on the cycle the final data or parity bit is driven.
REQ-021 The bit counter SHALL be $clog2(DATA_W+1) bits wide, and the gap counter SHALL be 4 bits wide; neither SHALL wrap within a frame.
REQ-022 s_data SHALL be ignored when no accept occurs, and a change in s_valid while a word is shifting SHALL have no effect on the current frame.

Reset
REQ-023 While rst=1 at a clock edge, the next-cycle values SHALL be: state=IDLE, counters=0, shift register=0, ser_out=0, ser_valid=0, word_done=0, busy=0, s_ready=0.
REQ-024 s_ready SHALL become 1 on the first cycle after rst deasserts.
REQ-025 A reset asserted mid-frame SHALL discard the word, with no further bits and no word_done.

Configuration
REQ-026 Macro BIT_SERIALIZER_PARITY_EN SHALL select the parity-bit feature.
REQ-027 With BIT_SERIALIZER_PARITY_EN undefined, each frame SHALL be DATA_W bits and the PAR state SHALL not exist.
REQ-028 With BIT_SERIALIZER_PARITY_EN defined, each frame SHALL append one even-parity bit (XOR of the word) after the data bits.
REQ-029 With the macro defined, the PAR state SHALL be entered, ser_valid SHALL be 1 during PAR, and word_done SHALL move to the parity cycle.

Structure
REQ-030 Package bit_serializer_pkg SHALL hold the state enum typedef (2-bit) and the DATA_W and GAP default constants.
REQ-031 The block SHALL be a single module with no sub-module, since the counter and shift register are trivial.

Verification
REQ-032 Reset scenario: hold rst 3 cycles -> ser_out=0, ser_valid=0, busy=0; s_ready=1 on the first cycle after release.
REQ-033 Single-word scenario: DATA_W=8, MSB_FIRST=1, accept 8'hB4 at cycle t -> cycles t+1..t+8 ser_out=1,0,1,1,0,1,0,0 with ser_valid=1, and word_done at t+8.
REQ-034 Back-to-back scenario: GAP=0, words 8'hFF then 8'h00 with s_valid held -> 16 consecutive ser_valid cycles, and s_ready high only at t and t+8.
REQ-035 Gap scenario: GAP=2, MSB_FIRST=0, accept 8'h01 twice -> ser_out=1 first, then 7 zeros, then 2 cycles with ser_valid=0 before the next frame.
REQ-036 Parity scenario: macro defined, words 8'hB4 then 8'h07 -> 9-bit frames with parity bits 0 and 1 respectively.
REQ-037 Reset-mid-word scenario: assert rst after bit 3 of 8'hB4 -> ser_valid=0 the next cycle, no word_done, and the block is IDLE after release.
